// File: rtl/sys_pll_supervisor_if.sv
// sys_pll_supervisor_if: PLL lock/status and control signals between the supervisor and its environment.
interface sys_pll_supervisor_if;
   logic        pll_locked;
   logic        retry_req;
   logic        clear_cnt;
   logic        pll_rst;
   logic        sys_rst_n;
   logic        lock_good;
   logic        relock_fail;
   logic [15:0] lock_loss_count;
   modport master (
      output pll_locked, retry_req, clear_cnt,
      input  pll_rst, sys_rst_n, lock_good, relock_fail, lock_loss_count
   );
   modport slave (
      input  pll_locked, retry_req, clear_cnt,
      output pll_rst, sys_rst_n, lock_good, relock_fail, lock_loss_count
   );
endinterface

// File: rtl/sys_pll_supervisor.sv
// sys_pll_supervisor: sequences PLL reset, lock qualification, retries and fault on refclk.
// Optional lock-loss counter is built only when SYS_PLL_SUP_LOSS_CNT_EN is defined.
module sys_pll_supervisor #(
   parameter int PLL_RST_CYCLES      = 16,
   parameter int LOCK_STABLE_CYCLES  = 1024,
   parameter int LOCK_TIMEOUT_CYCLES = 65536,
   parameter int MAX_RETRIES         = 8
) (
   input logic                 refclk,
   input logic                 rst_n,
   sys_pll_supervisor_if.slave sup
);
   localparam int TMAX = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES) > LOCK_TIMEOUT_CYCLES
                       ? (PLL_RST_CYCLES > LOCK_STABLE_CYCLES ? PLL_RST_CYCLES : LOCK_STABLE_CYCLES)
                       : LOCK_TIMEOUT_CYCLES;
   localparam int TW = $clog2(TMAX + 1);
   localparam int RW = MAX_RETRIES > 0 ? $clog2(MAX_RETRIES + 1) : 1;
   typedef enum logic [2:0] {RESET_PLL, WAIT_LOCK, STABILIZE, RUNNING, FAULT} state_t;
   state_t          state, state_nx;
   logic [TW-1:0]   tmr, tmr_nx;
   logic [RW-1:0]   retry, retry_nx;
   logic            s1, lk_s;
   always_ff @(posedge refclk)
      if (!rst_n) begin
         s1   <= 1'b0;
         lk_s <= 1'b0;
      end else begin
         s1   <= sup.pll_locked;
         lk_s <= s1;
      end
   // STABILIZE compares against the full count so release lands LOCK_STABLE_CYCLES+3 edges after lock
   always_comb begin
      state_nx = state;
      tmr_nx   = tmr + TW'(1);
      retry_nx = retry;
      case (state)
         RESET_PLL: if (tmr == TW'(PLL_RST_CYCLES - 1)) begin
            state_nx = WAIT_LOCK;
            tmr_nx   = '0;
         end
         WAIT_LOCK: if (lk_s) begin
            state_nx = STABILIZE;
            tmr_nx   = '0;
         end else if (tmr == TW'(LOCK_TIMEOUT_CYCLES - 1)) begin
            tmr_nx   = '0;
            state_nx = retry == RW'(MAX_RETRIES) ? FAULT : RESET_PLL;
            retry_nx = retry == RW'(MAX_RETRIES) ? retry : retry + RW'(1);
         end
         STABILIZE: if (!lk_s) begin
            state_nx = WAIT_LOCK;
            tmr_nx   = '0;
         end else if (tmr == TW'(LOCK_STABLE_CYCLES)) begin
            state_nx = RUNNING;
            tmr_nx   = '0;
            retry_nx = '0;
         end
         RUNNING: begin
            tmr_nx   = '0;
            state_nx = lk_s ? RUNNING : RESET_PLL;
         end
         FAULT: begin
            tmr_nx   = '0;
            state_nx = sup.retry_req ? RESET_PLL : FAULT;
            retry_nx = sup.retry_req ? '0 : retry;
         end
         default: begin
            state_nx = RESET_PLL;
            tmr_nx   = '0;
         end
      endcase
   end
   always_ff @(posedge refclk)
      if (!rst_n) begin
         state           <= RESET_PLL;
         tmr             <= '0;
         retry           <= '0;
         sup.pll_rst     <= 1'b1;
         sup.sys_rst_n   <= 1'b0;
         sup.lock_good   <= 1'b0;
         sup.relock_fail <= 1'b0;
      end else begin
         state           <= state_nx;
         tmr             <= tmr_nx;
         retry           <= retry_nx;
         sup.pll_rst     <= state_nx == RESET_PLL || state_nx == FAULT;
         sup.sys_rst_n   <= state_nx == RUNNING;
         sup.lock_good   <= state_nx == RUNNING;
         sup.relock_fail <= state_nx == FAULT;
      end
`ifdef SYS_PLL_SUP_LOSS_CNT_EN
   logic [15:0] cnt;
   logic        loss;
   assign loss = state == RUNNING && !lk_s;
   // a clear coinciding with a loss still records that loss
   always_ff @(posedge refclk)
      if (!rst_n)
         cnt <= '0;
      else if (sup.clear_cnt)
         cnt <= {15'd0, loss};
      else if (loss && cnt != 16'hffff)
         cnt <= cnt + 16'd1;
   assign sup.lock_loss_count = cnt;
`else
   logic unused_clear;
   assign unused_clear        = sup.clear_cnt;
   assign sup.lock_loss_count = '0;
`endif
endmodule

// File: tb/tb_sys_pll_supervisor.sv
// tb_sys_pll_supervisor: directed scenarios checked against a per-cycle behavioural model.
module tb_sys_pll_supervisor;
   localparam int PR = 4, LS = 8, LT = 32, MR = 2;
`ifdef SYS_PLL_SUP_LOSS_CNT_EN
   localparam bit CNT_EN = 1'b1;
`else
   localparam bit CNT_EN = 1'b0;
`endif
   localparam int P_RST = 0, P_WAIT = 1, P_STAB = 2, P_RUN = 3, P_FAULT = 4;
   logic refclk = 1'b0;
   logic rst_n  = 1'b0;
   logic preload = 1'b0;
   int   total = 0, bad = 0;
   always #5 refclk = ~refclk;
   sys_pll_supervisor_if sup();
   sys_pll_supervisor #(
      .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS),
      .LOCK_TIMEOUT_CYCLES(LT), .MAX_RETRIES(MR)
   ) dut (.refclk(refclk), .rst_n(rst_n), .sup(sup));
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, want %0d at %0t", name, act, exp, $time);
      end
   endtask
   // model: phase plus cycles elapsed in it, lock seen two edges late
   int ph = P_RST, el = 0, tries = 0, lcnt = 0;
   bit q1 = 0, q2 = 0, armed = 0;
   always @(posedge refclk) begin : mdl
      bit lk;
      if (!rst_n) begin
         ph = P_RST; el = 0; tries = 0; q1 = 0; q2 = 0; lcnt = 0; armed = 1;
      end else begin
         lk = q2; q2 = q1; q1 = sup.pll_locked;
         if (preload) lcnt = 65535;
         if (ph == P_RUN && !lk) lcnt = sup.clear_cnt ? 1 : (lcnt < 65535 ? lcnt + 1 : lcnt);
         else if (sup.clear_cnt) lcnt = 0;
         if (ph == P_RST) begin
            el++;
            if (el == PR) begin ph = P_WAIT; el = 0; end
         end else if (ph == P_WAIT) begin
            if (lk) begin ph = P_STAB; el = 0; end
            else begin
               el++;
               if (el == LT) begin
                  el = 0;
                  if (tries == MR) ph = P_FAULT;
                  else begin tries++; ph = P_RST; end
               end
            end
         end else if (ph == P_STAB) begin
            if (!lk) begin ph = P_WAIT; el = 0; end
            else if (el == LS) begin ph = P_RUN; el = 0; tries = 0; end
            else el++;
         end else if (ph == P_RUN) begin
            if (!lk) begin ph = P_RST; el = 0; end
         end else if (sup.retry_req) begin
            ph = P_RST; el = 0; tries = 0;
         end
      end
   end
   always @(posedge refclk) begin
      #1;
      if (armed) begin
         chk("m_pll_rst", sup.pll_rst, ph == P_RST || ph == P_FAULT);
         chk("m_sys_rst_n", sup.sys_rst_n, ph == P_RUN);
         chk("m_lock_good", sup.lock_good, ph == P_RUN);
         chk("m_relock_fail", sup.relock_fail, ph == P_FAULT);
         chk("m_loss_count", sup.lock_loss_count, CNT_EN ? lcnt : 0);
      end
   end
   function automatic logic sel(input int w);
      return w == 0 ? sup.pll_rst : w == 1 ? sup.sys_rst_n : sup.relock_fail;
   endfunction
   task automatic edges_until(input int w, input logic val, output int n);
      n = -1;
      for (int i = 1; i <= 200; i++) begin
         @(posedge refclk); #1;
         if (sel(w) === val) begin n = i; break; end
      end
   endtask
   task automatic relock(input string name);
      int n;
      @(negedge refclk); sup.pll_locked = 1'b1;
      @(posedge refclk); #1;
      chk({name, "_no_pll_rst"}, sup.pll_rst, 1'b0);
      edges_until(1, 1'b1, n);
      chk(name, n, 11);
      chk({name, "_lock_good"}, sup.lock_good, 1'b1);
   endtask
   task automatic drop_and_pulse(input string name);
      int n;
      @(negedge refclk); sup.pll_locked = 1'b0;
      edges_until(1, 1'b0, n);
      chk({name, "_sys_rst_edges"}, n, 3);
      edges_until(0, 1'b0, n);
      chk({name, "_pll_rst_width"}, n, 4);
   endtask
   initial begin
      int n, fault_at;
      int falls[$], rises[$];
      logic prev;
      sup.pll_locked = 1'b0; sup.retry_req = 1'b0; sup.clear_cnt = 1'b0;
      repeat (3) @(negedge refclk);
      chk("rst_pll_rst", sup.pll_rst, 1'b1);
      chk("rst_sys_rst_n", sup.sys_rst_n, 1'b0);
      chk("rst_lock_good", sup.lock_good, 1'b0);
      chk("rst_relock_fail", sup.relock_fail, 1'b0);
      chk("rst_count", sup.lock_loss_count, 0);
      rst_n = 1'b1;
      edges_until(0, 1'b0, n);
      chk("first_pulse_width", n, 4);
      repeat (6) @(negedge refclk);
      relock("first_release");
      drop_and_pulse("loss1");
      chk("loss1_count", sup.lock_loss_count, CNT_EN ? 1 : 0);
      relock("relock1");
      drop_and_pulse("loss2");
      @(negedge refclk); sup.pll_locked = 1'b1;
      repeat (5) @(negedge refclk);
      sup.pll_locked = 1'b0;
      relock("glitch_release");
      chk("loss2_count", sup.lock_loss_count, CNT_EN ? 2 : 0);
      @(negedge refclk); sup.retry_req = 1'b1;
      @(negedge refclk); sup.retry_req = 1'b0;
      repeat (2) @(negedge refclk);
      chk("retry_ignored", sup.lock_good, 1'b1);
`ifdef SYS_PLL_SUP_LOSS_CNT_EN
      @(negedge refclk); preload = 1'b1; force dut.cnt = 16'hffff;
      @(negedge refclk); preload = 1'b0; release dut.cnt;
      drop_and_pulse("loss_sat");
      chk("sat_count", sup.lock_loss_count, 16'hffff);
      relock("relock_sat");
`endif
      @(negedge refclk); sup.pll_locked = 1'b0;
      @(negedge refclk);
      @(negedge refclk); sup.clear_cnt = 1'b1;
      @(negedge refclk); sup.clear_cnt = 1'b0;
      chk("clear_with_loss", sup.lock_loss_count, CNT_EN ? 1 : 0);
      edges_until(0, 1'b0, n);
      relock("relock_clr");
      @(negedge refclk); sup.clear_cnt = 1'b1;
      @(negedge refclk); sup.clear_cnt = 1'b0;
      chk("clear_only", sup.lock_loss_count, 0);
      drop_and_pulse("loss3");
      @(negedge refclk); sup.pll_locked = 1'b1;
      repeat (4) @(negedge refclk);
      rst_n = 1'b0; sup.pll_locked = 1'b0;
      repeat (2) @(negedge refclk);
      chk("midstab_rst_pll_rst", sup.pll_rst, 1'b1);
      chk("midstab_rst_sys_rst_n", sup.sys_rst_n, 1'b0);
      chk("midstab_rst_count", sup.lock_loss_count, 0);
      rst_n = 1'b1;
      prev = 1'b1; fault_at = -1;
      for (int k = 1; k <= 300; k++) begin
         @(posedge refclk); #1;
         if (prev && !sup.pll_rst) falls.push_back(k);
         if (!prev && sup.pll_rst) rises.push_back(k);
         prev = sup.pll_rst;
         if (sup.relock_fail) begin fault_at = k; break; end
      end
      chk("fault_edge", fault_at, 108);
      chk("pulse_count", falls.size(), 3);
      chk("fall0", falls.size() > 0 ? falls[0] : -1, 4);
      chk("fall1", falls.size() > 1 ? falls[1] : -1, 40);
      chk("fall2", falls.size() > 2 ? falls[2] : -1, 76);
      chk("rise0", rises.size() > 0 ? rises[0] : -1, 36);
      chk("rise1", rises.size() > 1 ? rises[1] : -1, 72);
      chk("rise2", rises.size() > 2 ? rises[2] : -1, 108);
      repeat (10) @(negedge refclk);
      chk("fault_hold_relock_fail", sup.relock_fail, 1'b1);
      chk("fault_hold_pll_rst", sup.pll_rst, 1'b1);
      @(negedge refclk); sup.retry_req = 1'b1;
      @(posedge refclk); #1;
      chk("retry_relock_fail", sup.relock_fail, 1'b0);
      chk("retry_pll_rst", sup.pll_rst, 1'b1);
      @(negedge refclk); sup.retry_req = 1'b0;
      edges_until(0, 1'b0, n);
      chk("retry_pulse_width", n, 4);
      relock("relock_after_fault");
      repeat (3) @(negedge refclk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sys_pll_supervisor.md
SYS_PLL_SUPERVISOR -- requirements
Module: sys_pll_supervisor

Interface
REQ-001 Parameter PLL_RST_CYCLES, default 16: cycles pll_rst is held high per PLL reset pulse.
REQ-002 Parameter LOCK_STABLE_CYCLES, default 1024: consecutive synchronized-locked cycles required before release.
REQ-003 Parameter LOCK_TIMEOUT_CYCLES, default 65536: cycles to wait for lock after a PLL reset pulse.
REQ-004 Parameter MAX_RETRIES, default 8: number of timeout-triggered PLL reset retries before fault.
REQ-005 refclk  in  1  the only clock, free-running board reference (50 MHz); one clock; reset is synchronous and active-low.
REQ-006 rst_n  in  1  synchronous active-low reset.
REQ-007 pll_locked  in  1  asynchronous lock indication from the system PLL.
REQ-008 retry_req  in  1  single-cycle pulse; leaves FAULT and restarts the sequence.
REQ-009 clear_cnt  in  1  single-cycle pulse; clears lock_loss_count.
REQ-010 pll_rst  out  1  active-high reset to the system PLL.
REQ-011 sys_rst_n  out  1  active-low reset for logic clocked by the PLL output clocks.
REQ-012 lock_good  out  1  high only in RUNNING.
REQ-013 relock_fail  out  1  high only in FAULT.
REQ-014 lock_loss_count  out  16  count of lock losses in RUNNING.

Function
REQ-015 pll_locked SHALL pass through a 2-flop synchronizer; lk_s is the second-flop output, and no other logic SHALL sample pll_locked.
REQ-016 States: RESET_PLL, WAIT_LOCK, STABILIZE, RUNNING, FAULT; all outputs registered, updated on the same edge as the state register.
REQ-017 RESET_PLL: pll_rst=1, sys_rst_n=0; after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK with timer cleared.
REQ-018 WAIT_LOCK: pll_rst=0; lk_s=1 -> STABILIZE; timer reaching LOCK_TIMEOUT_CYCLES with lk_s=0 -> RESET_PLL and retry counter +1, or FAULT if retry counter already equals MAX_RETRIES.
REQ-019 STABILIZE: counts consecutive lk_s=1 cycles; count reaching LOCK_STABLE_CYCLES -> RUNNING and retry counter cleared; lk_s=0 -> WAIT_LOCK with timer restarted, retry counter unchanged.
REQ-020 With pll_locked steady high, sys_rst_n SHALL rise exactly LOCK_STABLE_CYCLES+3 refclk edges after the first edge that samples pll_locked high.
REQ-021 RUNNING: sys_rst_n=1, lock_good=1; lk_s=0 -> RESET_PLL, sys_rst_n=0 and lock_good=0 on that same edge, lock_loss_count +1.
REQ-022 FAULT: pll_rst=1, sys_rst_n=0, relock_fail=1; retry_req -> RESET_PLL with retry counter cleared; retry_req outside FAULT is ignored.
REQ-023 lock_loss_count saturates at 0xFFFF; clear_cnt and a loss event on the same cycle SHALL yield 1.
REQ-024 All timers are sized for their parameter with no wrap-around.

Reset
REQ-025 While rst_n=0: state RESET_PLL, pll_rst=1, sys_rst_n=0, lock_good=0, relock_fail=0, lock_loss_count=0, retry counter, timers and synchronizer flops=0.
REQ-026 rst_n asserted in any state, including mid-STABILIZE or FAULT, SHALL take effect on the next edge and restart a full PLL_RST_CYCLES pulse.

Configuration
REQ-027 Macro SYS_PLL_SUP_LOSS_CNT_EN defined: lock_loss_count and clear_cnt operate per REQ-021/023.
REQ-028 Macro undefined: no counter logic is built; lock_loss_count is constant 0; clear_cnt is ignored; all other behaviour is identical.

Verification (PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2)
REQ-029 Release rst_n, raise pll_locked 10 cycles later and hold -> pll_rst high exactly 4 cycles after reset, sys_rst_n=1 exactly 11 edges after pll_locked sampled high, lock_good=1.
REQ-030 Drop pll_locked for 1 cycle mid-STABILIZE -> no pll_rst pulse; sys_rst_n rises 11 edges after the restored high.
REQ-031 Hold pll_locked low -> exactly 3 pll_rst pulses of 4 cycles, 32 cycles apart, then relock_fail=1 and pll_rst held high; retry_req -> new 4-cycle pulse with relock_fail=0.
REQ-032 In RUNNING, drop pll_locked -> sys_rst_n=0 within 3 edges, lock_loss_count=1, 4-cycle pll_rst pulse, relock completes.
REQ-033 Preload lock_loss_count to 0xFFFF, trigger loss -> stays 0xFFFF; clear_cnt on the same cycle as a loss -> 1.
REQ-034 Rebuild without SYS_PLL_SUP_LOSS_CNT_EN and rerun REQ-032 -> lock_loss_count stays 0; all other outputs identical.
